// File: rtl/ecc_job_arbiter.sv
// Round-robin arbiter that shares one ECC core between two requesters.
// It loads X/Y/K into the core, watches for done or timeout, returns the result and cools the core down.
module ecc_job_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned COOL_CYCLES    = 2,
  parameter int unsigned TMR_W          = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req,
  input  logic [127:0] x0,
  input  logic [127:0] y0,
  input  logic [127:0] k0,
  input  logic [127:0] x1,
  input  logic [127:0] y1,
  input  logic [127:0] k1,
  output logic [1:0]   gnt,
  output logic [1:0]   rsp_valid,
  output logic         rsp_err,
  output logic [127:0] rsp_dx,
  output logic [127:0] rsp_dy,
  output logic         busy,
  output logic         owner,
  output logic         core_enable,
  output logic [127:0] core_din,
  input  logic         core_done,
  input  logic [127:0] core_dx,
  input  logic [127:0] core_dy
);

  localparam int unsigned CoolW = (COOL_CYCLES > 1) ? $clog2(COOL_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TmrLast  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CoolW-1:0] CoolLast = CoolW'(COOL_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StCompute, StResp, StCool} state_e;

  state_e state_q, state_d;

  logic             rr_q, rr_d;
  logic             owner_q, owner_d;
  logic [1:0]       load_cnt_q, load_cnt_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CoolW-1:0] cool_cnt_q, cool_cnt_d;
  logic [127:0]     x_q, x_d, y_q, y_d, k_q, k_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic [127:0]     rsp_dx_q, rsp_dx_d, rsp_dy_q, rsp_dy_d;
  logic             busy_q, busy_d;
  logic             core_enable_q, core_enable_d;
  logic [127:0]     core_din_q, core_din_d;

  logic       win;
  logic [1:0] win_mask;
  logic [1:0] own_mask;
  logic       timed_out;

  // With both ports requesting, the round-robin pointer decides.
  assign win       = (req == 2'b11) ? rr_q : req[1];
  assign win_mask  = win ? 2'b10 : 2'b01;
  assign own_mask  = owner_q ? 2'b10 : 2'b01;
  assign timed_out = (timer_q == TmrLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (req != 2'b00) state_d = StLoad;
      StLoad:    if (load_cnt_q == 2'd2) state_d = StCompute;
      StCompute: if (core_done || timed_out) state_d = StResp;
      StResp:    state_d = StCool;
      StCool:    if (cool_cnt_q == CoolLast) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Registered outputs are computed one cycle ahead, keyed on the state being entered.
  always_comb begin
    gnt_d         = 2'b00;
    rsp_valid_d   = 2'b00;
    core_din_d    = '0;
    rsp_err_d     = rsp_err_q;
    rsp_dx_d      = rsp_dx_q;
    rsp_dy_d      = rsp_dy_q;
    owner_d       = owner_q;
    rr_d          = rr_q;
    x_d           = x_q;
    y_d           = y_q;
    k_d           = k_q;
    load_cnt_d    = load_cnt_q;
    timer_d       = timer_q;
    cool_cnt_d    = cool_cnt_q;
    busy_d        = (state_d != StIdle);
    core_enable_d = (state_d == StLoad) || (state_d == StCompute);
    unique case (state_q)
      StIdle: begin
        if (req != 2'b00) begin
          gnt_d      = win_mask;
          owner_d    = win;
          load_cnt_d = 2'd0;
          x_d        = win ? x1 : x0;
          y_d        = win ? y1 : y0;
          k_d        = win ? k1 : k0;
          core_din_d = x_d;
        end
      end
      StLoad: begin
        load_cnt_d = load_cnt_q + 2'd1;
        case (load_cnt_q)
          2'd0:    core_din_d = y_q;
          2'd1:    core_din_d = k_q;
          default: core_din_d = '0;
        endcase
        if (load_cnt_q == 2'd2) timer_d = '0;
      end
      StCompute: begin
        if (timer_q != '1) timer_d = timer_q + 1'b1;
        // A done in the final timer cycle still counts as success.
        if (core_done) begin
          rsp_dx_d    = core_dx;
          rsp_dy_d    = core_dy;
          rsp_err_d   = 1'b0;
          rsp_valid_d = own_mask;
        end else if (timed_out) begin
          rsp_dx_d    = '0;
          rsp_dy_d    = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = own_mask;
        end
      end
      StResp: begin
        rr_d       = ~owner_q;
        cool_cnt_d = '0;
      end
      StCool: cool_cnt_d = cool_cnt_q + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q          <= 1'b0;
      owner_q       <= 1'b0;
      load_cnt_q    <= '0;
      timer_q       <= '0;
      cool_cnt_q    <= '0;
      x_q           <= '0;
      y_q           <= '0;
      k_q           <= '0;
      gnt_q         <= '0;
      rsp_valid_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_dx_q      <= '0;
      rsp_dy_q      <= '0;
      busy_q        <= 1'b0;
      core_enable_q <= 1'b0;
      core_din_q    <= '0;
    end else begin
      rr_q          <= rr_d;
      owner_q       <= owner_d;
      load_cnt_q    <= load_cnt_d;
      timer_q       <= timer_d;
      cool_cnt_q    <= cool_cnt_d;
      x_q           <= x_d;
      y_q           <= y_d;
      k_q           <= k_d;
      gnt_q         <= gnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      rsp_dx_q      <= rsp_dx_d;
      rsp_dy_q      <= rsp_dy_d;
      busy_q        <= busy_d;
      core_enable_q <= core_enable_d;
      core_din_q    <= core_din_d;
    end
  end

  assign gnt         = gnt_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_dx      = rsp_dx_q;
  assign rsp_dy      = rsp_dy_q;
  assign busy        = busy_q;
  assign owner       = owner_q;
  assign core_enable = core_enable_q;
  assign core_din    = core_din_q;

endmodule

// File: tb/tb_ecc_job_arbiter.sv
// Bench for ecc_job_arbiter: jobs are driven from the requester side with an in-bench core model.
// Expected grants, latencies and results come from a job-level model of the arbitration rules.
module tb_ecc_job_arbiter;

  localparam int TO = 50;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req = 2'b00;
  logic [127:0] x0 = '0, y0 = '0, k0 = '0, x1 = '0, y1 = '0, k1 = '0;
  logic         core_done = 1'b0;
  logic [127:0] core_dx = '0, core_dy = '0;
  logic [1:0]   gnt, rsp_valid;
  logic         rsp_err, busy, owner, core_enable;
  logic [127:0] rsp_dx, rsp_dy, core_din;

  int checks = 0;
  int errors = 0;
  int rr_m = 0;  // model round-robin pointer

  ecc_job_arbiter #(
    .TIMEOUT_CYCLES(TO),
    .COOL_CYCLES   (2),
    .TMR_W         (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .x0         (x0),
    .y0         (y0),
    .k0         (k0),
    .x1         (x1),
    .y1         (y1),
    .k1         (k1),
    .gnt        (gnt),
    .rsp_valid  (rsp_valid),
    .rsp_err    (rsp_err),
    .rsp_dx     (rsp_dx),
    .rsp_dy     (rsp_dy),
    .busy       (busy),
    .owner      (owner),
    .core_enable(core_enable),
    .core_din   (core_din),
    .core_done  (core_done),
    .core_dx    (core_dx),
    .core_dy    (core_dy)
  );

  always #10 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic set_req(input int p, input logic v);
    if (p == 0) req[0] = v;
    else req[1] = v;
  endtask

  // One full job from the requester's view. side_kind: 1 = pulse other port's req,
  // 2 = raise other port's req and hold it, 3 = core_done pulse during LOAD cycle 1.
  task automatic do_job(input int port, input logic [127:0] x, input logic [127:0] y,
                        input logic [127:0] k, input int done_at, input logic [127:0] dx,
                        input logic [127:0] dy, input int side_kind, input int side_at,
                        output int gnt_wait);
    logic [1:0]   pm;
    logic         own_e;
    int           other, steps, exp_steps, low, stray, n;
    bit           exp_err;
    logic [127:0] exp_dx, exp_dy;
    pm    = (port == 1) ? 2'b10 : 2'b01;
    own_e = (port == 1);
    other = (port == 1) ? 0 : 1;
    if (port == 0) begin x0 = x; y0 = y; k0 = k; end
    else begin x1 = x; y1 = y; k1 = k; end
    set_req(port, 1'b1);
    exp_err   = !(done_at >= 0 && done_at < TO);
    exp_steps = exp_err ? TO : done_at + 1;
    exp_dx    = exp_err ? '0 : dx;
    exp_dy    = exp_err ? '0 : dy;

    gnt_wait = 0;
    do begin step(); gnt_wait++; end while (gnt == 2'b00 && gnt_wait < 100);
    checks++;
    if (gnt !== pm) begin
      errors++; $display("FAIL gnt: got %b, expected %b (port %0d)", gnt, pm, port);
    end
    checks++;
    if (owner !== own_e || busy !== 1'b1 || core_enable !== 1'b1) begin
      errors++; $display("FAIL grant_state: owner=%b busy=%b en=%b, expected owner=%b busy=1 en=1",
                         owner, busy, core_enable, own_e);
    end
    checks++;
    if (core_din !== x) begin
      errors++; $display("FAIL din_x: got %h, expected %h", core_din, x);
    end
    step();
    if (side_kind == 3) begin core_done = 1'b1; core_dx = rnd128(); core_dy = rnd128(); end
    checks++;
    if (core_din !== y) begin
      errors++; $display("FAIL din_y: got %h, expected %h", core_din, y);
    end
    step();
    core_done = 1'b0;
    checks++;
    if (core_din !== k || rsp_valid !== 2'b00) begin
      errors++; $display("FAIL din_k: got %h rsp_valid=%b, expected %h rsp_valid=00",
                         core_din, rsp_valid, k);
    end
    step();
    checks++;
    if (core_din !== '0 || core_enable !== 1'b1) begin
      errors++; $display("FAIL compute_entry: din=%h en=%b, expected din=0 en=1",
                         core_din, core_enable);
    end

    steps = 0;
    while (rsp_valid == 2'b00 && steps < TO + 10) begin
      if (steps == done_at) begin core_done = 1'b1; core_dx = dx; core_dy = dy; end
      else begin core_done = 1'b0; core_dx = rnd128(); core_dy = rnd128(); end
      if (side_kind == 1 && steps == side_at) set_req(other, 1'b1);
      if (side_kind == 1 && steps == side_at + 1) set_req(other, 1'b0);
      if (side_kind == 2 && steps == side_at) set_req(other, 1'b1);
      step();
      steps++;
    end
    core_done = 1'b0;
    checks++;
    if (steps !== exp_steps) begin
      errors++; $display("FAIL rsp_latency: got %0d cycles after COMPUTE entry, expected %0d",
                         steps, exp_steps);
    end
    checks++;
    if (rsp_valid !== pm || rsp_err !== exp_err) begin
      errors++; $display("FAIL rsp_flags: rsp_valid=%b err=%b, expected %b err=%b",
                         rsp_valid, rsp_err, pm, exp_err);
    end
    checks++;
    if (rsp_dx !== exp_dx || rsp_dy !== exp_dy) begin
      errors++; $display("FAIL rsp_data: dx=%h dy=%h, expected dx=%h dy=%h",
                         rsp_dx, rsp_dy, exp_dx, exp_dy);
    end
    set_req(port, 1'b0);
    rr_m = other;

    low   = (busy && !core_enable) ? 1 : 0;
    stray = 0;
    n     = 0;
    do begin
      step(); n++;
      if (busy && !core_enable) low++;
      if (busy && (gnt != 2'b00 || rsp_valid != 2'b00)) stray++;
    end while (busy && n < 10);
    checks++;
    if (low !== 3 || stray !== 0) begin
      errors++; $display("FAIL cool_gap: enable-low busy cycles=%0d stray pulses=%0d, expected 3 and 0",
                         low, stray);
    end
    checks++;
    if (busy !== 1'b0 || core_enable !== 1'b0 || rsp_err !== exp_err || rsp_dx !== exp_dx) begin
      errors++; $display("FAIL idle_hold: busy=%b en=%b err=%b dx=%h, expected 0 0 %b %h",
                         busy, core_enable, rsp_err, rsp_dx, exp_err, exp_dx);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    checks++;
    if ({gnt, rsp_valid, rsp_err, busy, owner, core_enable} !== 8'h00 ||
        rsp_dx !== '0 || rsp_dy !== '0 || core_din !== '0) begin
      errors++; $display("FAIL reset_outputs: gnt=%b rsp_valid=%b err=%b busy=%b en=%b din=%h, expected all 0",
                         gnt, rsp_valid, rsp_err, busy, core_enable, core_din);
    end
    rst_n = 1'b1;
    rr_m  = 0;
    step();
    checks++;
    if (gnt !== 2'b00 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_no_req: gnt=%b busy=%b, expected 00 0", gnt, busy);
    end
  endtask

  task automatic test_single_port0();
    int w;
    do_job(0, 128'h1, 128'h2, 128'h3, 10, 128'hAA, 128'hBB, 0, 0, w);
  endtask

  task automatic test_simultaneous();
    int w, exp_p;
    req = 2'b11;
    for (int j = 0; j < 4; j++) begin
      exp_p = rr_m;
      checks++;
      if (exp_p !== (j % 2)) begin
        errors++; $display("FAIL rr_order: model winner %0d at job %0d, expected %0d", exp_p, j, j % 2);
      end
      do_job(exp_p, rnd128(), rnd128(), rnd128(), $urandom_range(0, 20), rnd128(), rnd128(), 0, 0, w);
      checks++;
      if (w !== 1) begin
        errors++; $display("FAIL sim_gnt_wait: got %0d cycles, expected 1", w);
      end
      req = 2'b11;
    end
    req = 2'b00;
    step();
  endtask

  task automatic test_timeout();
    int w;
    do_job(1, rnd128(), rnd128(), rnd128(), -1, rnd128(), rnd128(), 0, 0, w);
    do_job(1, rnd128(), rnd128(), rnd128(), 5, rnd128(), rnd128(), 0, 0, w);
  endtask

  task automatic test_early_done_and_tie();
    int w;
    do_job(0, rnd128(), rnd128(), rnd128(), 8, rnd128(), rnd128(), 3, 0, w);
    do_job(1, rnd128(), rnd128(), rnd128(), TO - 1, rnd128(), rnd128(), 0, 0, w);
  endtask

  task automatic test_req_pulse();
    int w, seen;
    do_job(1, rnd128(), rnd128(), rnd128(), 6, rnd128(), rnd128(), 1, 2, w);
    seen = 0;
    repeat (5) begin
      step();
      if (gnt != 2'b00 || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL pulse_ignored: %0d cycles with gnt/busy, expected 0", seen);
    end
  endtask

  task automatic test_late_request();
    int w;
    do_job(0, rnd128(), rnd128(), rnd128(), 7, rnd128(), rnd128(), 2, 3, w);
    do_job(1, rnd128(), rnd128(), rnd128(), 4, rnd128(), rnd128(), 0, 0, w);
    checks++;
    if (w !== 1) begin
      errors++; $display("FAIL late_gnt_wait: got %0d cycles after COOL, expected 1", w);
    end
  endtask

  task automatic test_reset_mid();
    int w, bad;
    logic [127:0] xx, yy, kk;
    xx = rnd128(); yy = rnd128(); kk = rnd128();
    x1 = xx; y1 = yy; k1 = kk;
    req[1] = 1'b1;
    w = 0;
    do begin step(); w++; end while (gnt == 2'b00 && w < 20);
    repeat (7) step();
    checks++;
    if (busy !== 1'b1 || core_enable !== 1'b1) begin
      errors++; $display("FAIL pre_reset: busy=%b en=%b, expected 1 1", busy, core_enable);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, rsp_valid, rsp_err, busy, owner, core_enable} !== 8'h00 ||
        rsp_dx !== '0 || rsp_dy !== '0 || core_din !== '0) begin
      errors++; $display("FAIL async_reset: gnt=%b rsp_valid=%b err=%b busy=%b owner=%b en=%b, expected all 0",
                         gnt, rsp_valid, rsp_err, busy, owner, core_enable);
    end
    rr_m = 0;
    bad = 0;
    repeat (3) begin
      step();
      if (rsp_valid != 2'b00 || busy) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL reset_quiet: %0d cycles with rsp_valid/busy, expected 0", bad);
    end
    rst_n = 1'b1;
    do_job(1, xx, yy, kk, 4, rnd128(), rnd128(), 0, 0, w);
    checks++;
    if (w !== 1) begin
      errors++; $display("FAIL regrant_wait: got %0d cycles, expected 1", w);
    end
  endtask

  task automatic test_random();
    int w, p, d;
    for (int i = 0; i < 16; i++) begin
      p = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 1) begin
        req = 2'b11;
        p   = rr_m;
      end
      d = $urandom_range(0, TO + 5);
      do_job(p, rnd128(), rnd128(), rnd128(), d, rnd128(), rnd128(), 0, 0, w);
      checks++;
      if (w !== 1) begin
        errors++; $display("FAIL rand_gnt_wait: got %0d cycles, expected 1", w);
      end
      req = 2'b00;
    end
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_single_port0();
    test_timeout();
    test_early_done_and_tie();
    test_req_pulse();
    test_late_request();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ecc_job_arbiter.md
Name: ecc_job_arbiter

Overview:
Shares one 128-bit ECC core between two requesters, e.g. the SPI host path (port 0) and an on-chip self-test/DMA path (port 1). Requests are granted round-robin. For each granted job the block latches the operands, sequences the core's load cycles (X, Y, K on core_din), and supervises computation with a timeout. It then returns the result to the winning requester and holds the core disabled for a cool-down gap before the next job.

Parameters:
TIMEOUT_CYCLES, 1000000, max clk cycles in COMPUTE before the job is aborted with an error
COOL_CYCLES, 2, cycles core_enable is held low between jobs (minimum 1)
TMR_W, 20, width of the timeout counter; must satisfy 2^TMR_W > TIMEOUT_CYCLES

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  reset
req  in  2  per-requester job request, level; held until rsp_valid for that port
x0, y0, k0  in  128 each  requester 0 operands, stable while req[0]=1
x1, y1, k1  in  128 each  requester 1 operands, stable while req[1]=1
gnt  out  2  one-cycle pulse; operands of that port latched this cycle
rsp_valid  out  2  one-cycle pulse to owning requester; result valid
rsp_err  out  1  valid with rsp_valid; 1 = timeout abort
rsp_dx, rsp_dy  out  128 each  result; held until next RESP
busy  out  1  high in every state except IDLE
owner  out  1  index of current or last granted requester
core_enable  out  1  to ECC core enable
core_din  out  128  to ECC core din
core_done  in  1  from ECC core reg_done
core_dx, core_dy  in  128 each  from ECC core dx/dy

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- Reset values: all outputs 0; internal state IDLE; round-robin pointer rr=0; operand latches and counters 0.
- Reset during any state aborts immediately. No rsp_valid is issued, and core_enable drops asynchronously.
- States: IDLE, LOAD, COMPUTE, RESP, COOL. All outputs are registered.
- IDLE:
  - If req != 0, select the winner. If both are high, rr wins; otherwise the single requester wins.
  - Next cycle: enter LOAD with gnt[winner]=1, owner=winner, load_cnt=0, core_enable=1.
  - Operands of the winner are latched on the IDLE->LOAD edge.
- LOAD, 3 cycles:
  - core_din = X, Y, K for load_cnt = 0, 1, 2.
  - core_enable=1. core_done is ignored.
  - After load_cnt=2, go to COMPUTE with timer=0.
- COMPUTE:
  - core_enable=1; core_din=0; timer increments each cycle.
  - If core_done=1: capture core_dx/core_dy into rsp_dx/rsp_dy, set rsp_err=0, go to RESP.
  - Else if timer == TIMEOUT_CYCLES-1: rsp_dx=rsp_dy=0, rsp_err=1, go to RESP.
  - If core_done and timeout coincide, core_done wins (rsp_err=0).
- RESP, 1 cycle:
  - rsp_valid[owner]=1; core_enable=0.
  - rr = ~owner, so the other port has priority next.
  - Go to COOL with cool_cnt=0.
- COOL, COOL_CYCLES cycles:
  - core_enable=0, which resets the core for the next job.
  - Then go to IDLE.
- A req still high in IDLE after COOL is a new job. Requesters must drop req the cycle after rsp_valid.
- Arbitration timing:
  - req changes while busy=1 have no effect until IDLE.
  - req dropped before gnt means no job is started.
  - A new req during COMPUTE on the other port waits; it is never preempted.
- Latency: req seen in IDLE -> gnt after 1 cycle. First core_enable cycle = gnt cycle. rsp_valid = core_done + 1 cycle.
- core_din is 0 outside LOAD. rsp_err holds its value until the next RESP.
- Timer saturates and never wraps: TMR_W is sized per the parameter rule.

Test Plan:
- Single job, port 0:
  - Stimulus: x0=128'h1, y0=128'h2, k0=128'h3; model core asserts done 10 cycles after LOAD ends with dx=128'hAA, dy=128'hBB.
  - Required: gnt=2'b01; core_din sequence 1, 2, 3; rsp_valid=2'b01 one cycle after done; rsp_dx=AA, rsp_dy=BB, rsp_err=0.
  - Required: core_enable low for exactly 3 cycles (RESP + 2 COOL).
- Simultaneous requests:
  - Stimulus: req=2'b11 from reset, both held after each response.
  - Required: grants alternate 0, 1, 0, 1 over 4 jobs; owner matches; no overlapping gnt.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=50; core never asserts done.
  - Required: rsp_valid 50 cycles after COMPUTE entry; rsp_err=1; rsp_dx=rsp_dy=0; next job proceeds normally.
- Done/timeout tie and early done:
  - Stimulus: core_done pulsed during LOAD cycle 1.
  - Required: pulse ignored; job still waits for a done in COMPUTE.
  - Stimulus: core_done exactly at timer=TIMEOUT_CYCLES-1.
  - Required: rsp_err=0 and the result is captured.
- Reset mid-COMPUTE:
  - Stimulus: rst_n low for 3 cycles during COMPUTE with req[1]=1.
  - Required: all outputs 0 immediately, no rsp_valid, rr=0; after release, job regranted to port 1 via gnt=2'b10.
- Request withdrawn / late request:
  - Stimulus: req[0] pulsed for 1 cycle while busy.
  - Required: no gnt for that pulse.
  - Stimulus: req[1] asserted during COMPUTE of a port-0 job.
  - Required: gnt=2'b10 one cycle after COOL ends.
